// File: rtl/uart_mon_pkg.sv
// Shared types and constants for the bench-side UART receive monitor.
package uart_mon_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int MID_TICK   = 7;

    localparam logic [1:0] CHAR_LEN_5 = 2'b00;
    localparam logic [1:0] CHAR_LEN_6 = 2'b01;
    localparam logic [1:0] CHAR_LEN_7 = 2'b10;
    localparam logic [1:0] CHAR_LEN_8 = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_DATA    = 3'd2,
        S_PARITY  = 3'd3,
        S_STOP    = 3'd4,
        S_BRKWAIT = 3'd5
    } state_t;

    typedef struct packed {
        logic       brk;
        logic       ferr;
        logic       perr;
        logic [7:0] data;
    } rx_stat_t;

    localparam int STAT_W = $bits(rx_stat_t);

    // Data shifts in from the MSB end, so short characters sit in the top bits.
    function automatic logic [7:0] align_char(input logic [7:0] shreg, input logic [1:0] char_len);
        logic [7:0] res;
        res = shreg;
        case (char_len)
            CHAR_LEN_5: res = {3'b000, shreg[7:3]};
            CHAR_LEN_6: res = {2'b00, shreg[7:2]};
            CHAR_LEN_7: res = {1'b0, shreg[7:1]};
            CHAR_LEN_8: res = shreg;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/uart_rx_monitor_fifo.sv
// Synchronous FIFO with a valid/ready read port; head is zero while empty.
module sync_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    output logic             empty,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_data
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wptr, rptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             pop, push;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign pop   = !empty && rd_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push  = wr_en && (!full || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= wr_data;
    end

    assign rd_data = empty ? '0 : mem[rptr[AW-1:0]];

endmodule

// File: rtl/uart_rx_monitor.sv
// 16550-style serial receiver: 16x oversampling, 5-8 bits, parity, framing,
// break and overrun detection, characters delivered through a small FIFO.
module uart_rx_monitor
    import uart_mon_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [15:0] divisor,
    input  logic [1:0]  char_len,
    input  logic        parity_en,
    input  logic        even_par,
    input  logic        stick_par,
    input  logic        rx,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_perr,
    output logic        out_ferr,
    output logic        out_brk,
    output logic        overrun,
    input  logic        clr_overrun,
    output logic        busy
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    state_t                 state, state_d;
    logic [15:0]            presc;
    logic                   tick, bit_tick, mid_tick;
    logic [3:0]             tick_cnt;
    logic [2:0]             bit_cnt;
    logic [7:0]             shreg, data_al;
    logic                   par_q, perr_q, par_exp;
    logic                   brk_now, last_bit;
    logic                   restart, mid_clr, sample_data, sample_par, sample_stop;
    logic                   push_q;
    rx_stat_t               stat_q, head;
    logic                   fifo_full, fifo_empty, drop;

    // Resetting to 1 keeps reset release from looking like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '1;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
    end
    assign rx_s = sync_q[SYNC_STAGES-1];

    assign tick     = (divisor != 16'd0) && (presc == 16'd0);
    assign bit_tick = tick && (tick_cnt == 4'(OVERSAMPLE - 1));
    assign mid_tick = tick && (tick_cnt == 4'(MID_TICK));
    assign data_al  = align_char(shreg, char_len);
    assign last_bit = (bit_cnt == ({1'b0, char_len} + 3'd4));
    assign par_exp  = stick_par ? ~even_par : (^data_al ^ ~even_par);
    assign brk_now  = ~rx_s && (data_al == 8'd0) && (!parity_en || !par_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d     = state;
        restart     = 1'b0;
        mid_clr     = 1'b0;
        sample_data = 1'b0;
        sample_par  = 1'b0;
        sample_stop = 1'b0;
        if (!enable) begin
            state_d = S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (!rx_s) begin
                    state_d = S_START;
                    restart = 1'b1;
                end
                S_START: if (mid_tick) begin
                    mid_clr = 1'b1;
                    state_d = rx_s ? S_IDLE : S_DATA;
                end
                S_DATA: if (bit_tick) begin
                    sample_data = 1'b1;
                    if (last_bit) state_d = parity_en ? S_PARITY : S_STOP;
                end
                S_PARITY: if (bit_tick) begin
                    sample_par = 1'b1;
                    state_d    = S_STOP;
                end
                // A low stop bit without break re-enters IDLE, which resyncs on the low level.
                S_STOP: if (bit_tick) begin
                    sample_stop = 1'b1;
                    state_d     = brk_now ? S_BRKWAIT : S_IDLE;
                end
                S_BRKWAIT: if (rx_s) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc    <= '0;
            tick_cnt <= '0;
        end else begin
            if (restart || tick)      presc <= divisor - 16'd1;
            else if (presc != 16'd0)  presc <= presc - 16'd1;
            if (restart || mid_clr)   tick_cnt <= '0;
            else if (tick)            tick_cnt <= tick_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg   <= '0;
            bit_cnt <= '0;
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
            push_q  <= 1'b0;
            stat_q  <= '0;
        end else begin
            push_q <= sample_stop;
            if (restart) begin
                shreg   <= '0;
                bit_cnt <= '0;
                par_q   <= 1'b0;
                perr_q  <= 1'b0;
            end else if (sample_data) begin
                shreg   <= {rx_s, shreg[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end else if (sample_par) begin
                par_q  <= rx_s;
                perr_q <= (rx_s != par_exp);
            end
            if (sample_stop) begin
                stat_q.brk  <= brk_now;
                stat_q.ferr <= ~rx_s;
                stat_q.perr <= perr_q;
                stat_q.data <= brk_now ? 8'd0 : data_al;
            end
        end
    end

    sync_fifo #(
        .WIDTH (STAT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (push_q),
        .wr_data  (stat_q),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .rd_ready (out_ready),
        .rd_data  (head)
    );

    assign out_valid = !fifo_empty;
    assign out_data  = head.data;
    assign out_perr  = head.perr;
    assign out_ferr  = head.ferr;
    assign out_brk   = head.brk;
    assign busy      = (state != S_IDLE);
    assign drop      = push_q && fifo_full && !(out_valid && out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           overrun <= 1'b0;
        else if (drop)        overrun <= 1'b1;
        else if (clr_overrun) overrun <= 1'b0;
    end

endmodule

// File: tb/tb_uart_rx_monitor.sv
// Directed bench for uart_rx_monitor: table of frames plus hand-written corner sequences.
module tb_uart_rx_monitor;
    logic        clk = 1'b0;
    logic        rst_n, enable, parity_en, even_par, stick_par, rx;
    logic [15:0] divisor;
    logic [1:0]  char_len;
    logic        out_valid, out_ready, out_perr, out_ferr, out_brk, overrun, clr_overrun, busy;
    logic [7:0]  out_data;
    int          n_chk = 0;
    int          n_pass = 0;

    typedef struct {
        logic [7:0] d;
        int         nbits;
        bit         pen, even, stick, pbit, stop;
        int         div;
        logic [7:0] xd;
        bit         xp, xf, xb;
    } vec_t;
    vec_t vecs[9];

    uart_rx_monitor #(.DEPTH(4), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .divisor(divisor), .char_len(char_len),
        .parity_en(parity_en), .even_par(even_par), .stick_par(stick_par), .rx(rx),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_perr(out_perr),
        .out_ferr(out_ferr), .out_brk(out_brk), .overrun(overrun), .clr_overrun(clr_overrun),
        .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no finish, expected completion within time limit");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic hold(input logic b, input int n);
        rx = b;
        idle(n);
    endtask

    task automatic set_cfg(input int div, input int nbits, input bit pen, input bit even, input bit stick);
        divisor   = 16'(div);
        char_len  = 2'(nbits - 5);
        parity_en = pen;
        even_par  = even;
        stick_par = stick;
    endtask

    task automatic send_frame(input logic [7:0] d, input int nbits, input bit pen, input bit pbit,
                              input bit stop, input int div);
        int bt;
        bt = 16 * div;
        hold(1'b0, bt);
        for (int i = 0; i < nbits; i++) hold(d[i], bt);
        if (pen) hold(pbit, bt);
        hold(stop, bt);
        rx = 1'b1;
    endtask

    task automatic wait_valid(input string nm);
        int n;
        n = 0;
        while (!out_valid && n < 2000) begin
            idle(1);
            n++;
        end
        chk(nm, 32'(out_valid), 1);
    endtask

    task automatic pop();
        out_ready = 1'b1;
        idle(1);
        out_ready = 1'b0;
    endtask

    task automatic chk_entry(input string nm, input logic [7:0] d, input bit p, input bit f, input bit b);
        chk({nm, "_data"}, 32'(out_data), 32'(d));
        chk({nm, "_perr"}, 32'(out_perr), 32'(p));
        chk({nm, "_ferr"}, 32'(out_ferr), 32'(f));
        chk({nm, "_brk"},  32'(out_brk),  32'(b));
    endtask

    initial begin
        //            d      nb pen ev st pb sp div  xd    xp xf xb
        vecs[0] = '{8'h41, 7, 1, 1, 0, 1, 1, 2, 8'h41, 1, 0, 0};
        vecs[1] = '{8'h41, 7, 1, 1, 0, 0, 1, 2, 8'h41, 0, 0, 0};
        vecs[2] = '{8'hA3, 8, 0, 0, 0, 0, 0, 1, 8'hA3, 0, 1, 0};
        vecs[3] = '{8'h12, 8, 0, 0, 0, 0, 1, 1, 8'h12, 0, 0, 0};
        vecs[4] = '{8'h15, 5, 1, 0, 0, 0, 1, 1, 8'h15, 0, 0, 0};
        vecs[5] = '{8'h2A, 6, 1, 1, 1, 1, 1, 1, 8'h2A, 1, 0, 0};
        vecs[6] = '{8'h2A, 6, 1, 0, 1, 1, 1, 3, 8'h2A, 0, 0, 0};
        vecs[7] = '{8'h00, 8, 0, 0, 0, 0, 1, 1, 8'h00, 0, 0, 0};
        vecs[8] = '{8'h00, 7, 1, 1, 0, 1, 0, 1, 8'h00, 1, 1, 0};

        rst_n = 1'b0; enable = 1'b1; rx = 1'b1; out_ready = 1'b0; clr_overrun = 1'b0;
        set_cfg(1, 8, 0, 0, 0);
        idle(3);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_data", 32'(out_data), 0);
        chk("rst_perr", 32'(out_perr), 0);
        chk("rst_ferr", 32'(out_ferr), 0);
        chk("rst_brk", 32'(out_brk), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_busy", 32'(busy), 0);
        rst_n = 1'b1;
        idle(5);

        // 8N1 at divisor 1: stop sample lands 155 clks after the start edge, valid one clk later
        fork
            send_frame(8'h55, 8, 0, 0, 1, 1);
            begin
                idle(155);
                chk("lat_before", 32'(out_valid), 0);
                idle(1);
                chk("lat_rise", 32'(out_valid), 1);
            end
        join
        hold(1'b1, 20);
        chk_entry("c55", 8'h55, 0, 0, 0);
        pop();
        chk("c55_empty", 32'(out_valid), 0);

        for (int v = 0; v < 9; v++) begin
            set_cfg(vecs[v].div, vecs[v].nbits, vecs[v].pen, vecs[v].even, vecs[v].stick);
            send_frame(vecs[v].d, vecs[v].nbits, vecs[v].pen, vecs[v].pbit, vecs[v].stop, vecs[v].div);
            hold(1'b1, 20 * vecs[v].div);
            wait_valid($sformatf("vec%0d_valid", v));
            chk_entry($sformatf("vec%0d", v), vecs[v].xd, vecs[v].xp, vecs[v].xf, vecs[v].xb);
            pop();
            chk($sformatf("vec%0d_empty", v), 32'(out_valid), 0);
        end

        // break: line low for three frame times
        set_cfg(1, 8, 0, 0, 0);
        hold(1'b0, 480);
        chk("brk_valid", 32'(out_valid), 1);
        chk_entry("brk", 8'h00, 0, 1, 1);
        chk("brk_busy", 32'(busy), 1);
        pop();
        idle(100);
        chk("brk_single", 32'(out_valid), 0);
        chk("brk_wait_busy", 32'(busy), 1);
        hold(1'b1, 40);
        chk("brk_release_busy", 32'(busy), 0);
        chk("brk_release_empty", 32'(out_valid), 0);

        // overrun with a 4-deep FIFO
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 8, 0, 0, 1, 1);
            hold(1'b1, 20);
        end
        chk("ovr_set", 32'(overrun), 1);
        chk("ovr_head", 32'(out_data), 1);
        clr_overrun = 1'b1;
        idle(1);
        clr_overrun = 1'b0;
        chk("ovr_clr", 32'(overrun), 0);
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("ovr_drain%0d_valid", i), 32'(out_valid), 1);
            chk($sformatf("ovr_drain%0d_data", i), 32'(out_data), 32'(i));
            pop();
        end
        chk("ovr_drain_empty", 32'(out_valid), 0);

        // short glitch is a false start
        hold(1'b0, 4);
        chk("glitch_busy", 32'(busy), 1);
        hold(1'b1, 30);
        chk("glitch_idle", 32'(busy), 0);
        chk("glitch_empty", 32'(out_valid), 0);

        // reset in the middle of DATA with an entry already queued
        send_frame(8'h5A, 8, 0, 0, 1, 1);
        hold(1'b1, 20);
        chk("prerst_valid", 32'(out_valid), 1);
        hold(1'b0, 16);
        hold(1'b1, 16);
        hold(1'b0, 8);
        chk("prerst_busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(out_valid), 0);
        chk("midrst_data", 32'(out_data), 0);
        chk("midrst_perr", 32'(out_perr), 0);
        chk("midrst_ferr", 32'(out_ferr), 0);
        chk("midrst_brk", 32'(out_brk), 0);
        chk("midrst_busy", 32'(busy), 0);
        rx = 1'b1;
        idle(3);
        rst_n = 1'b1;
        hold(1'b1, 20);
        send_frame(8'h7E, 8, 0, 0, 1, 1);
        hold(1'b1, 20);
        wait_valid("c7e_valid");
        chk_entry("c7e", 8'h7E, 0, 0, 0);
        pop();
        chk("c7e_empty", 32'(out_valid), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_rx_monitor.md
Name: uart_rx_monitor

Overview:
- Bench-side serial receiver that consumes one quad-UART transmit line (uart_tx_N) and recovers characters for the checker.
- Reproduces 16550 receive semantics: 16x oversampling, 5–8 data bits, optional parity, framing, break and overrun detection.
- Received characters and per-character status go into a small FIFO read through a valid/ready handshake.
- One instance per UART channel, clocked by the wishbone clock.

Parameters:
- DEPTH, 16, number of FIFO entries; power of two, minimum 2.
- SYNC_STAGES, 2, number of flops synchronising the rx input; minimum 2.

Ports:
- clk  in  1  wishbone clock; everything is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  receiver enable; when low, the FSM is held in IDLE and the FIFO is kept.
- divisor  in  16  16x tick period in clk cycles; 0 means no ticks.
- char_len  in  2  00=5, 01=6, 10=7, 11=8 data bits.
- parity_en  in  1  parity bit present.
- even_par  in  1  1=even parity, 0=odd parity.
- stick_par  in  1  stick parity: the expected bit is ~even_par.
- rx  in  1  serial line (the DUT uart_tx); idles high.
- out_valid  out  1  FIFO is not empty.
- out_ready  in  1  consumer accepts the head entry.
- out_data  out  8  head character; unused upper bits are 0.
- out_perr  out  1  head entry has a parity error.
- out_ferr  out  1  head entry has a framing error.
- out_brk  out  1  head entry is a break.
- overrun  out  1  sticky; set when a character is dropped.
- clr_overrun  in  1  one-cycle pulse that clears overrun.
- busy  out  1  FSM is not in IDLE.

Behaviour:
- Reset: FSM goes to IDLE; the FIFO is emptied; the prescaler and bit counters are cleared.
- Reset output values: out_valid=0, out_data=0, out_perr/out_ferr/out_brk=0, overrun=0, busy=0.
- The synchroniser resets to 1, so reset does not create a false start bit.
- Prescaler: a 16-bit down-counter produces a one-cycle tick every `divisor` clks.
  - A new divisor value takes effect on the next reload.
  - divisor=0: no ticks and no state progress.
- rx_s is the synchronised rx, delayed by SYNC_STAGES clks.
- FSM states: IDLE, START, DATA, PARITY, STOP, BRKWAIT.
  - IDLE: when enable=1 and rx_s=0, go to START, clear the tick count and restart the prescaler.
  - START: on the 8th tick, sample rx_s (bit centre).
    - rx_s=1: false start, return to IDLE with no push.
    - rx_s=0: go to DATA.
  - DATA: sample every 16 ticks, LSB first, shifting into the data register.
    - After char_len+5 bits, go to PARITY if parity_en, otherwise go to STOP.
  - PARITY: sample once after 16 ticks.
    - Expected bit = stick_par ? ~even_par : (^data ^ ~even_par).
    - perr = (sample != expected).
  - STOP: sample once after 16 ticks; ferr = (sample == 0).
    - Break = ferr, data all zero, and (parity_en ? parity sample == 0 : 1); in that case brk=1 and data=0.
    - Push {brk, ferr, perr, data} in the cycle after the stop sample.
    - Next state: BRKWAIT if brk, IDLE if stop sample = 1, otherwise IDLE (resynchronise on the low level).
  - Only the first stop bit is checked; a second stop bit is treated as idle.
  - BRKWAIT: stay until rx_s=1, then go to IDLE. Exactly one break entry is pushed per break.
- enable deasserted mid-frame: abort to IDLE with no push.
- FIFO:
  - Registered output; an entry becomes visible on out_* one clk after the push.
  - A pop happens when out_valid and out_ready are both 1.
  - Push while full with no pop in the same cycle: the new character is dropped, overrun=1, and the FIFO is unchanged.
  - Push and pop in the same cycle while full: both happen and no overrun is raised.
  - Push and pop in the same cycle while empty: the push is stored and out_valid rises next cycle.
- overrun is cleared by clr_overrun. If a clear and a set happen in the same cycle, the set wins.
- Pointers are log2(DEPTH)+1 bits wide: full when the MSBs differ and the rest are equal; pointers wrap naturally.
- Latency: out_valid rises 2 clks after the stop-bit sample tick.

Decomposition:
- Shared package uart_mon_pkg holds:
  - state encoding constants;
  - a status struct {brk, ferr, perr, data[7:0]};
  - CHAR_LEN encodings;
  - OVERSAMPLE=16 and MID_TICK=7.
- Sub-module sync_fifo (parameterised width and depth, valid/ready read port, full/empty) is instantiated once with width 11.

Test Plan:
- divisor=1, 8N1, rx sends 0x55 (160 clks/frame) -> one entry: out_data=0x55, perr=ferr=brk=0; out_valid rises 2 clks after the stop sample.
- divisor=2, 7E1, send 0x41 with the parity bit forced to 1 -> out_data=0x41, out_perr=1, out_ferr=0. Repeat with correct parity 0 -> out_perr=0.
- 8N1, send 0xA3 with the stop bit driven 0, then rx high -> out_data=0xA3, out_ferr=1, brk=0. The next frame 0x12 is received cleanly.
- Hold rx=0 for 3 frame times, then release -> exactly one entry: data=0x00, brk=1, ferr=1. No further entries until rx returns high.
- DEPTH=4, out_ready=0, send 5 characters 0x01..0x05 -> FIFO holds 0x01..0x04 and overrun=1.
  - Pulse clr_overrun -> overrun=0.
  - Drain -> exactly 4 entries.
- Glitch rx low for 4 clks at divisor=1 -> no entry and FSM back in IDLE.
- Assert rst_n=0 mid-DATA -> all outputs 0 immediately; the next clean 0x7E frame is received correctly.
